m_pool_arbiter: RTL and testbench
=================================

Name: m_pool_arbiter

Overview:
Shares a node pool of CAPACITY slots between N_REQ requesters. It arbitrates alloc and free requests with independent round-robin arbiters. It keeps the registered occupancy count and drives full, empty and almost_full status. It sits between the linked-list client ports and the node pool. Each alloc grant hands a client one slot; each free grant returns one slot.

Parameters:
N_REQ, 4, number of requesters (2..8)
N_BITS, 4, occupancy counter width
CAPACITY, 15, pool size in slots; must be <= 2**N_BITS-1
AF_THRESH, 12, almost_full asserts when occupancy >= AF_THRESH (must be <= CAPACITY)

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
alloc_req  in  N_REQ  per-requester request for one slot; held high until granted
free_req  in  N_REQ  per-requester request to return one slot; held high until granted
alloc_gnt  out  N_REQ  one-hot or zero; combinational grant, same cycle as request
free_gnt  out  N_REQ  one-hot or zero; combinational grant, same cycle as request
occupancy  out  N_BITS  slots currently allocated (registered)
full  out  1  occupancy == CAPACITY
empty  out  1  occupancy == 0
almost_full  out  1  occupancy >= AF_THRESH

Behaviour:
- Reset (async, rst_n low) forces:
  - occupancy = 0, so empty = 1, full = 0, almost_full = 0.
  - Both round-robin pointers = 0.
  - alloc_gnt and free_gnt are 0 while rst_n is low, regardless of requests.
- Handshake:
  - A transfer occurs in the cycle where req[i] and gnt[i] are both high.
  - A requester drops req in the cycle after its grant, or keeps it high to request another slot.
  - Grant is combinational from the current req, pointer and status, so latency is 0 cycles. The occupancy effect is visible 1 cycle later.
- Alloc arbiter:
  - Eligible only when full = 0.
  - Grants the first requester with alloc_req set, searching upward from alloc_ptr with modulo-N_REQ wrap.
  - On a grant to index i, alloc_ptr <= (i+1) mod N_REQ.
  - With no grant the pointer holds.
  - When full = 1, alloc_gnt = 0 and the pointer holds. There is no bypass: an alloc is not granted in a full cycle even if a free fires in the same cycle.
- Free arbiter:
  - Same scheme with free_ptr.
  - Eligible only when empty = 0; when empty = 1, free_gnt = 0.
- Occupancy update, registered: occupancy <= occupancy + alloc_fire - free_fire, where alloc_fire = |alloc_gnt and free_fire = |free_gnt.
  - Alloc and free firing in the same cycle: occupancy is unchanged.
  - Counter enable = alloc_fire XOR free_fire.
- Overflow and underflow are impossible by construction; gating on full/empty guarantees it. No wrap-around ever occurs.
- The same requester may assert alloc_req and free_req together. Both arbiters treat them independently, so both may be granted in one cycle.
- full, empty and almost_full are decoded combinationally from the registered occupancy, so they change only on clock edges or reset.
- Reset mid-operation: outstanding requests are not remembered and grants drop immediately. After rst_n rises, arbitration restarts from pointer 0 with an empty pool.

Test Plan:
- Reset: rst_n=0 with alloc_req=4'b1111 -> alloc_gnt=0, occupancy=0, empty=1; rst_n=1 -> alloc_gnt=4'b0001 the same cycle.
- Round-robin: alloc_req=4'b1111 held 4 cycles -> grants 0001, 0010, 0100, 1000 in order; occupancy 0->4; almost_full=0.
- Fill to full: keep alloc_req=4'b0101 -> grants alternate 0001/0100.
  - Then, in order: occupancy reaches 12 -> almost_full=1; occupancy reaches 15 -> full=1, alloc_gnt=0 thereafter, occupancy stays 15.
- Simultaneous: occupancy=15 with alloc_req=4'b0001 and free_req=4'b0010 -> free_gnt=0010, alloc_gnt=0; next cycle occupancy=14. Then alloc and free both granted -> occupancy stays 14.
- Empty gating: occupancy=0, free_req=4'b1000 -> free_gnt=0 and occupancy stays 0. After one alloc grant: free_gnt=1000 next cycle, then occupancy back to 0.
- Async reset mid-fill: occupancy=7, pulse rst_n low between clock edges -> occupancy=0 and grants=0 immediately; pointers=0 on release.

Source files
------------

// File: rtl/m_pool_arbiter.sv
// Node-pool slot arbiter: round-robin alloc/free grants shared by N_REQ clients,
// with a registered occupancy count and full/empty/almost_full status decode.
module m_pool_arbiter #(
  parameter int N_REQ     = 4,
  parameter int N_BITS    = 4,
  parameter int CAPACITY  = 15,
  parameter int AF_THRESH = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_REQ-1:0]  alloc_req,
  input  logic [N_REQ-1:0]  free_req,
  output logic [N_REQ-1:0]  alloc_gnt,
  output logic [N_REQ-1:0]  free_gnt,
  output logic [N_BITS-1:0] occupancy,
  output logic              full,
  output logic              empty,
  output logic              almost_full
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [PW-1:0]     alloc_ptr_reg, alloc_ptr_next;
  logic [PW-1:0]     free_ptr_reg, free_ptr_next;
  logic [N_BITS-1:0] occ_reg, occ_next;
  logic              alloc_fire, free_fire;

  // First set request at or above ptr, wrapping modulo N_REQ.
  function automatic logic [N_REQ-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                              input logic [PW-1:0]    ptr);
    logic [N_REQ-1:0] g;
    logic             found;
    logic [PW:0]      idx;
    g     = '0;
    found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = {1'b0, ptr} + (PW+1)'(k);
      if (idx >= (PW+1)'(N_REQ)) idx = idx - (PW+1)'(N_REQ);
      if (!found && req[idx[PW-1:0]]) begin
        g[idx[PW-1:0]] = 1'b1;
        found          = 1'b1;
      end
    end
    return g;
  endfunction

  function automatic logic [PW-1:0] ptr_after(input logic [N_REQ-1:0] g,
                                              input logic [PW-1:0]    ptr);
    logic [PW-1:0] p;
    p = ptr;
    for (int i = 0; i < N_REQ; i++) begin
      if (g[i]) p = (i == N_REQ - 1) ? '0 : PW'(i + 1);
    end
    return p;
  endfunction

  // No bypass: a full pool never grants alloc, an empty pool never grants free,
  // so the counter cannot wrap.
  assign alloc_gnt = (rst_n && !full)  ? rr_pick(alloc_req, alloc_ptr_reg) : '0;
  assign free_gnt  = (rst_n && !empty) ? rr_pick(free_req, free_ptr_reg)   : '0;

  assign alloc_fire = |alloc_gnt;
  assign free_fire  = |free_gnt;

  always_comb begin
    alloc_ptr_next = ptr_after(alloc_gnt, alloc_ptr_reg);
    free_ptr_next  = ptr_after(free_gnt, free_ptr_reg);
    occ_next       = occ_reg;
    if (alloc_fire ^ free_fire) begin
      occ_next = alloc_fire ? occ_reg + N_BITS'(1) : occ_reg - N_BITS'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alloc_ptr_reg <= '0;
      free_ptr_reg  <= '0;
      occ_reg       <= '0;
    end else begin
      alloc_ptr_reg <= alloc_ptr_next;
      free_ptr_reg  <= free_ptr_next;
      occ_reg       <= occ_next;
    end
  end

  assign occupancy   = occ_reg;
  assign full        = (occ_reg == N_BITS'(CAPACITY));
  assign empty       = (occ_reg == '0);
  assign almost_full = (occ_reg >= N_BITS'(AF_THRESH));

endmodule

// File: tb/tb_m_pool_arbiter.sv
// Scoreboard bench for m_pool_arbiter: the stimulus process queues per-cycle
// expectations, a monitor pops and checks them on each falling edge.
module tb_m_pool_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] alloc_req, free_req;
  logic [3:0] alloc_gnt, free_gnt;
  logic [3:0] occupancy;
  logic       full, empty, almost_full;

  typedef struct {
    logic [3:0] ag;
    logic [3:0] fg;
    logic [3:0] occ;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   ncyc  = 0;

  m_pool_arbiter #(.N_REQ(4), .N_BITS(4), .CAPACITY(15), .AF_THRESH(12)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .alloc_req   (alloc_req),
    .free_req    (free_req),
    .alloc_gnt   (alloc_gnt),
    .free_gnt    (free_gnt),
    .occupancy   (occupancy),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int cyc, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%b want=%b", name, cyc, act, exp);
    end
  endtask

  // Monitor: one transaction per queued cycle, sampled mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        ncyc++;
        chk("alloc_gnt",   ncyc, alloc_gnt,   e.ag);
        chk("free_gnt",    ncyc, free_gnt,    e.fg);
        chk("occupancy",   ncyc, occupancy,   e.occ);
        chk("full",        ncyc, {3'b0, full},        {3'b0, e.occ == 4'd15});
        chk("empty",       ncyc, {3'b0, empty},       {3'b0, e.occ == 4'd0});
        chk("almost_full", ncyc, {3'b0, almost_full}, {3'b0, e.occ >= 4'd12});
        $display("cyc %0d ag=%b fg=%b occ=%0d f=%b e=%b af=%b", ncyc, alloc_gnt,
                 free_gnt, occupancy, full, empty, almost_full);
      end
    end
  end

  // One cycle of stimulus; a pulse releases reset between edges with requests cleared.
  task automatic step(input logic r, input logic [3:0] a, input logic [3:0] f,
                      input logic [3:0] eag, input logic [3:0] efg,
                      input logic [3:0] eocc, input bit pulse);
    exp_t e;
    rst_n     = r;
    alloc_req = a;
    free_req  = f;
    e.ag = eag; e.fg = efg; e.occ = eocc;
    sb.push_back(e);
    @(negedge clk);
    #1;
    if (pulse) begin
      alloc_req = 4'b0;
      free_req  = 4'b0;
      rst_n     = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] onehot;
    rst_n = 1'b0; alloc_req = 4'b1111; free_req = 4'b0;
    @(posedge clk);
    #1;
    // Reset holds grants low; release mid-cycle grants requester 0 at once
    step(1'b0, 4'b1111, 4'b0, 4'b0000, 4'b0, 4'd0, 1'b0);
    step(1'b1, 4'b1111, 4'b0, 4'b0001, 4'b0, 4'd0, 1'b0);
    step(1'b1, 4'b1111, 4'b0, 4'b0010, 4'b0, 4'd1, 1'b0);
    step(1'b1, 4'b1111, 4'b0, 4'b0100, 4'b0, 4'd2, 1'b0);
    step(1'b1, 4'b1111, 4'b0, 4'b1000, 4'b0, 4'd3, 1'b0);
    // Fill 4 -> 15 with requesters 0 and 2 alternating
    for (int k = 0; k < 11; k++) begin
      onehot = (k % 2 == 0) ? 4'b0001 : 4'b0100;
      step(1'b1, 4'b0101, 4'b0, onehot, 4'b0, 4'(4 + k), 1'b0);
    end
    step(1'b1, 4'b0101, 4'b0, 4'b0000, 4'b0, 4'd15, 1'b0);
    step(1'b1, 4'b0101, 4'b0, 4'b0000, 4'b0, 4'd15, 1'b0);
    // Full: free only; then both fire and occupancy holds
    step(1'b1, 4'b0001, 4'b0010, 4'b0000, 4'b0010, 4'd15, 1'b0);
    step(1'b1, 4'b0001, 4'b0010, 4'b0001, 4'b0010, 4'd14, 1'b0);
    step(1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'd14, 1'b0);
    // Drain 14 -> 0, free pointer starting at 2
    for (int k = 0; k < 14; k++) begin
      onehot = 4'b0001 << ((2 + k) % 4);
      step(1'b1, 4'b0, 4'b1111, 4'b0, onehot, 4'(14 - k), 1'b0);
    end
    // Empty gating
    step(1'b1, 4'b0000, 4'b1000, 4'b0000, 4'b0000, 4'd0, 1'b0);
    step(1'b1, 4'b0001, 4'b1000, 4'b0001, 4'b0000, 4'd0, 1'b0);
    step(1'b1, 4'b0000, 4'b1000, 4'b0000, 4'b1000, 4'd1, 1'b0);
    step(1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'd0, 1'b0);
    // Refill to 7 leaving alloc pointer at 1
    for (int k = 0; k < 6; k++) begin
      onehot = 4'b0001 << ((1 + k) % 4);
      step(1'b1, 4'b1111, 4'b0, onehot, 4'b0, 4'(k), 1'b0);
    end
    step(1'b1, 4'b0001, 4'b0, 4'b0001, 4'b0, 4'd6, 1'b0);
    // Async reset pulse mid-cycle, then restart from pointer 0
    step(1'b0, 4'b1111, 4'b1111, 4'b0000, 4'b0000, 4'd0, 1'b1);
    step(1'b1, 4'b1111, 4'b0000, 4'b0001, 4'b0000, 4'd0, 1'b0);
    step(1'b1, 4'b0000, 4'b1111, 4'b0000, 4'b0001, 4'd1, 1'b0);
    step(1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'd0, 1'b0);

    for (int w = 0; w < 4 && sb.size() > 0; w++) @(posedge clk);
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_drain left=%0d want=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
